// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector.
// Registered one-cycle detect pulse plus a saturating match counter.
module seq_detect_param #(
  parameter int                 SEQ_LEN = 5,
  parameter logic [SEQ_LEN-1:0] SEQ     = 5'b11011,
  parameter int                 OVERLAP = 0,
  parameter int                 CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  input  logic             in,
  input  logic             cnt_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int FW = $clog2(SEQ_LEN + 1);

  localparam logic [FW-1:0] FILL_MAX = FW'(SEQ_LEN);
  localparam logic [FW-1:0] FILL_ARM = FW'(SEQ_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [SEQ_LEN-1:0] hist;
  logic [SEQ_LEN-1:0] hist_nxt;
  logic [SEQ_LEN-1:0] cand;
  logic [FW-1:0]      fill;
  logic [FW-1:0]      fill_nxt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic               armed;
  logic               match;
  logic               out_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      hist      <= '0;
      fill      <= '0;
      out       <= 1'b0;
      match_cnt <= '0;
    end else begin
      hist      <= hist_nxt;
      fill      <= fill_nxt;
      out       <= out_nxt;
      match_cnt <= cnt_nxt;
    end
  end

  // Candidate window: current history with the incoming bit appended.
  always_comb begin
    cand  = {hist[SEQ_LEN-2:0], in};
    armed = (fill >= FILL_ARM);
    match = in_vld && armed && (cand == SEQ);
  end

  always_comb begin
    hist_nxt = hist;
    fill_nxt = fill;
    if (in_vld) begin
      hist_nxt = cand;
      if (match && (OVERLAP == 0)) begin
        fill_nxt = '0;
      end else if (fill != FILL_MAX) begin
        fill_nxt = fill + FW'(1);
      end
    end
  end

  // Clear wins over a coincident match; the pulse itself is unaffected.
  always_comb begin
    out_nxt = match;
    cnt_nxt = match_cnt;
    if (cnt_clr) begin
      cnt_nxt = '0;
    end else if (match && (match_cnt != CNT_MAX)) begin
      cnt_nxt = match_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: three configurations driven in parallel,
// checked every cycle against a bit-stream model plus literal expectations.
module tb_seq_detect_param;

  logic clk = 1'b0;
  logic rst;
  logic in_vld;
  logic in;
  logic cnt_clr;

  logic       d0_out, d1_out, d2_out;
  logic [7:0] d0_cnt, d1_cnt;
  logic [1:0] d2_cnt;

  int tests = 0;
  int errors = 0;
  bit run = 0;
  int p0 = 0, p1 = 0, p2 = 0;

  always #5 clk = ~clk;

  seq_detect_param #(
    .SEQ_LEN(5), .SEQ(5'b11011), .OVERLAP(0), .CNT_W(8)
  ) d0 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in),
    .cnt_clr(cnt_clr), .out(d0_out), .match_cnt(d0_cnt)
  );

  seq_detect_param #(
    .SEQ_LEN(5), .SEQ(5'b11011), .OVERLAP(1), .CNT_W(8)
  ) d1 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in),
    .cnt_clr(cnt_clr), .out(d1_out), .match_cnt(d1_cnt)
  );

  seq_detect_param #(
    .SEQ_LEN(2), .SEQ(2'b11), .OVERLAP(1), .CNT_W(2)
  ) d2 (
    .clk(clk), .rst(rst), .in_vld(in_vld), .in(in),
    .cnt_clr(cnt_clr), .out(d2_out), .match_cnt(d2_cnt)
  );

  // Model: remembers the accepted bit stream and how many of the most
  // recent bits are still allowed to take part in a match.
  typedef struct {
    int bits;
    int elig;
    int cnt;
    bit out;
  } mst_t;

  mst_t m0 = '{0, 0, 0, 0};
  mst_t m1 = '{0, 0, 0, 0};
  mst_t m2 = '{0, 0, 0, 0};

  function automatic mst_t step(mst_t s, int len, int seq, bit ov,
                                int cmax, bit r, bit v, bit i, bit c);
    mst_t n = s;
    int mask = (1 << len) - 1;
    if (r) begin
      n.bits = 0;
      n.elig = 0;
      n.cnt  = 0;
      n.out  = 0;
      return n;
    end
    n.out = 0;
    if (v) begin
      n.bits = ((s.bits << 1) | int'(i)) & mask;
      n.elig = (s.elig < 1000) ? s.elig + 1 : s.elig;
      if (n.elig >= len && n.bits == seq) begin
        n.out = 1;
        if (n.cnt < cmax) n.cnt = n.cnt + 1;
        if (!ov) n.elig = 0;
      end
    end
    if (c) n.cnt = 0;
    return n;
  endfunction

  always @(posedge clk) begin
    m0 = step(m0, 5, 27, 0, 255, rst, in_vld, in, cnt_clr);
    m1 = step(m1, 5, 27, 1, 255, rst, in_vld, in, cnt_clr);
    m2 = step(m2, 2, 3, 1, 3, rst, in_vld, in, cnt_clr);
  end

  task automatic chk(string nm, int act, int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (run) begin
      chk("d0.out", int'(d0_out), int'(m0.out));
      chk("d0.cnt", int'(d0_cnt), m0.cnt);
      chk("d0.hist", int'(d0.hist), m0.bits);
      chk("d1.out", int'(d1_out), int'(m1.out));
      chk("d1.cnt", int'(d1_cnt), m1.cnt);
      chk("d1.hist", int'(d1.hist), m1.bits);
      chk("d2.out", int'(d2_out), int'(m2.out));
      chk("d2.cnt", int'(d2_cnt), m2.cnt);
      chk("d2.hist", int'(d2.hist), m2.bits);
      p0 += int'(d0_out);
      p1 += int'(d1_out);
      p2 += int'(d2_out);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send(bit b);
    in_vld = 1'b1;
    in     = b;
    tick();
    in_vld = 1'b0;
  endtask

  task automatic do_rst();
    rst = 1'b1;
    in_vld = 1'b1;
    in = 1'b1;
    cnt_clr = 1'b0;
    tick();
    rst = 1'b0;
    in_vld = 1'b0;
    in = 1'b0;
    p0 = 0;
    p1 = 0;
    p2 = 0;
  endtask

  initial begin
    bit [7:0] s8;
    bit [5:0] s6;
    bit [4:0] s5;

    rst = 1'b1;
    in_vld = 1'b0;
    in = 1'b0;
    cnt_clr = 1'b0;
    tick();
    tick();
    chk("rst.d0.out", int'(d0_out), 0);
    chk("rst.d0.cnt", int'(d0_cnt), 0);
    chk("rst.d2.cnt", int'(d2_cnt), 0);
    chk("rst.d1.hist", int'(d1.hist), 0);
    run = 1;
    rst = 1'b0;
    p0 = 0;
    p1 = 0;
    p2 = 0;
    tick();

    s8 = 8'b11011011;
    for (int i = 7; i >= 0; i--) begin
      send(s8[i]);
      if (i == 3) begin
        chk("t25.d0.bit5", int'(d0_out), 1);
        chk("t26.d1.bit5", int'(d1_out), 1);
      end
      if (i == 0) begin
        chk("t25.d0.bit8", int'(d0_out), 0);
        chk("t26.d1.bit8", int'(d1_out), 1);
      end
    end
    tick();
    chk("t25.pulses", p0, 1);
    chk("t25.cnt", int'(d0_cnt), 1);
    chk("t26.pulses", p1, 2);
    chk("t26.cnt", int'(d1_cnt), 2);

    do_rst();
    chk("rst2.d1.cnt", int'(d1_cnt), 0);
    s6 = 6'b111011;
    for (int i = 5; i >= 0; i--) begin
      send(s6[i]);
      if (i == 1) chk("t27.bit5", int'(d0_out), 0);
      if (i == 0) chk("t27.bit6", int'(d0_out), 1);
    end
    tick();
    chk("t27.d0.pulses", p0, 1);
    chk("t27.d1.pulses", p1, 1);

    do_rst();
    send(1'b1);
    send(1'b1);
    send(1'b0);
    send(1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    send(1'b1);
    tick();
    chk("t28.d0.pulses", p0, 0);
    chk("t28.d1.pulses", p1, 0);
    chk("t28.d0.cnt", int'(d0_cnt), 0);

    do_rst();
    s5 = 5'b11011;
    for (int i = 4; i >= 0; i--) begin
      send(s5[i]);
      if (i == 0) chk("t29.final", int'(d0_out), 1);
      tick();
      tick();
      chk("t29.idle.out", int'(d0_out), 0);
      if (i == 1) chk("t29.idle.hist", int'(d0.hist), 13);
    end
    chk("t29.pulses", p0, 1);
    chk("t29.cnt", int'(d0_cnt), 1);

    do_rst();
    for (int i = 0; i < 6; i++) send(1'b1);
    tick();
    chk("t30.pulses", p2, 5);
    chk("t30.sat", int'(d2_cnt), 3);
    send(1'b1);
    chk("t30.sat.out", int'(d2_out), 1);
    chk("t30.sat.hold", int'(d2_cnt), 3);
    cnt_clr = 1'b1;
    send(1'b1);
    cnt_clr = 1'b0;
    chk("t30.clr.out", int'(d2_out), 1);
    chk("t30.clr.cnt", int'(d2_cnt), 0);
    send(1'b1);
    chk("t30.after", int'(d2_cnt), 1);
    send(1'b0);
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("t30.idleclr", int'(d2_cnt), 0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
